uart_rx_stream: RTL and testbench

UART_RX_STREAM -- requirements
Module: uart_rx_stream

---
 rtl/uart_rx_stream.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stream.sv
// UART receiver with a one-deep ready/valid holding register, packet counter and idle timeout.
// Optional even parity: define UART_PARITY_EN.
module uart_rx_stream #(
  parameter int CLKS_PER_BIT   = 35,
  parameter int DATA_BITS      = 8,
  parameter int NUM_PACKETS    = 256,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           rx,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_BITS-1:0]           out_data,
  output logic [$clog2(NUM_PACKETS)-1:0] packet_count,
  output logic                           buffer_finish,
  output logic                           frame_err,
  output logic                           parity_err,
  output logic                           overrun,
  output logic                           timeout
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_HIGH, TIMEOUT
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [TW-1:0]        tcnt;
  logic                 seen_good;
  logic                 par_bad;
  logic                 fall, byte_done, hs;

  // Flops reset to the idle level so release never looks like a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev & ~rx_s;
  assign byte_done = (state == STOP) && (cnt == HALF_C) && rx_s && !par_bad;
  assign hs        = out_valid & out_ready;

`ifndef UART_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      tcnt          <= '0;
      seen_good     <= 1'b0;
      timeout       <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      packet_count  <= '0;
      buffer_finish <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad       <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      buffer_finish <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err    <= 1'b0;
`endif
      cnt  <= (cnt == LAST_C) ? '0 : cnt + 1'b1;
      tcnt <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
          else if (seen_good) begin
            if (tcnt == TW'(TIMEOUT_CYCLES)) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
            end else tcnt <= tcnt + 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_C && rx_s) state <= IDLE;
          else if (cnt == LAST_C) begin
            state   <= DATA;
            bit_idx <= '0;
`ifdef UART_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (cnt == HALF_C) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (cnt == LAST_C) begin
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_PARITY_EN
            if (bit_idx == BW'(DATA_BITS - 1)) state <= PARITY;
`else
            if (bit_idx == BW'(DATA_BITS - 1)) state <= STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt == HALF_C && (^shreg ^ rx_s)) begin
            parity_err <= 1'b1;
            par_bad    <= 1'b1;
          end
          if (cnt == LAST_C) state <= STOP;
        end
`endif
        STOP: begin
          if (cnt == HALF_C) begin
            if (rx_s) begin
              state <= IDLE;
              if (!par_bad) seen_good <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        TIMEOUT: begin
          cnt     <= '0;
          timeout <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A same-cycle handshake frees the register for the new byte.
      if (byte_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= shreg;
          out_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (hs) out_valid <= 1'b0;

      if (hs) begin
        packet_count  <= packet_count + 1'b1;
        buffer_finish <= (packet_count == '1);
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: serial stimulus with a byte scoreboard checked at each handshake.
module tb_uart_rx_stream;
  localparam int CPB = 35;
  localparam int DB  = 8;
  localparam int NP  = 16;
  localparam int TO  = 2048;

  logic clk = 1'b0;
  logic n_rst, rx, out_ready;
  logic out_valid, buffer_finish, frame_err, parity_err, overrun, timeout;
  logic [DB-1:0] out_data;
  logic [$clog2(NP)-1:0] packet_count;

  always #5 clk = ~clk;

  uart_rx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .NUM_PACKETS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .rx(rx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .packet_count(packet_count), .buffer_finish(buffer_finish),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .timeout(timeout)
  );

  int checks = 0, errors = 0;
  int hs_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, bf_cnt = 0, bf_hs = -1, vh_cnt = 0;
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on every handshake, pulse counters for the flags.
  always @(negedge clk) begin
    if (out_valid === 1'b1) vh_cnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_byte: observed=%0h expected=none", out_data);
      end else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
    if (buffer_finish === 1'b1) begin
      bf_cnt++;
      bf_hs = hs_cnt;
    end
  end

  task automatic send(input logic [DB-1:0] b, input logic stop_bit, input logic flip);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ^b ^ flip;
`ifdef UART_PARITY_EN
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [DB-1:0] b;
    int v0;
    rx = 1'b1; out_ready = 1'b1; n_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_packet_count", 32'(packet_count), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_buffer_finish", 32'(buffer_finish), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame
    rx = 1'b0;
    repeat (100) @(negedge clk);
    n_rst = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (400) @(negedge clk);
    chk("abort_frame_err", fe_cnt, 0);
    chk("abort_out_valid", vh_cnt, 0);

    // Basic byte, consumer always ready
    v0 = vh_cnt;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("a5_handshakes", hs_cnt, 1);
    chk("a5_valid_cycles", vh_cnt - v0, 1);
    chk("a5_packet_count", 32'(packet_count), 1);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_handshakes", hs_cnt, 1);
    chk("glitch_frame_err", fe_cnt, 0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0);
    chk("3c_handshakes", hs_cnt, 2);
    chk("3c_packet_count", 32'(packet_count), 2);

    // Bad stop bit
    send(8'h5A, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_pulses", fe_cnt, 1);
    chk("ferr_handshakes", hs_cnt, 2);
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1, 1'b0);
    chk("after_ferr_handshakes", hs_cnt, 3);

    // Overrun: second byte dropped while first is held
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    chk("ovr_pulses", ov_cnt, 1);
    chk("ovr_out_valid", 32'(out_valid), 1);
    chk("ovr_out_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_handshakes", hs_cnt, 4);
    chk("ovr_valid_dropped", 32'(out_valid), 0);

    // Fill up to the packet count wrap
    for (int i = 0; i < NP - 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, 1'b1, 1'b0);
    end
    chk("prewrap_bf", bf_cnt, 0);
    chk("prewrap_packet_count", 32'(packet_count), NP - 1);
    b = 8'($urandom);
    exp_q.push_back(b);
    send(b, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("wrap_bf_pulses", bf_cnt, 1);
    chk("wrap_bf_on_last", bf_hs, NP);
    chk("wrap_packet_count", 32'(packet_count), 0);

`ifdef UART_PARITY_EN
    send(8'h81, 1'b1, 1'b1);
    chk("parity_pulses", pe_cnt, 1);
    chk("parity_handshakes", hs_cnt, NP);
`endif

    // Idle timeout with a byte still pending
    out_ready = 1'b0;
    exp_q.push_back(8'h42);
    send(8'h42, 1'b1, 1'b0);
    chk("pre_timeout", 32'(timeout), 0);
    repeat (TO + 200) @(negedge clk);
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_pending_valid", 32'(out_valid), 1);
    send(8'h55, 1'b1, 1'b0);
    chk("timeout_data_held", 32'(out_data), 32'h42);
    chk("timeout_no_overrun", ov_cnt, 1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("timeout_handshake", hs_cnt, NP + 1);
    chk("timeout_valid_clear", 32'(out_valid), 0);
    repeat (400) @(negedge clk);
    chk("timeout_sticky", 32'(timeout), 1);
    chk("timeout_no_more", hs_cnt, NP + 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
